fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch initiator for the RV32I pipeline. It owns the PC, drives the word address into the combinational-read instruction memory, and captures the returned word into the IF/ID pipeline register. It handles stall and branch/jump redirect from later stages, and a halt on EBREAK. It also provides a fetch counter for bring-up.

Parameters:
RESET_PC, 32'h00000000, byte address of the first instruction fetched after reset
NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) loaded into IF/ID on flush/boot
EBREAK_INSTR, 32'h00100073, encoding that triggers HALT

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hazard stall from ID/EX; hold PC and IF/ID
flush_i  input  1  taken branch/jump from EX; redirect PC and squash IF/ID
redirect_pc_i  input  32  byte target address, valid when flush_i=1
imem_addr_o  output  32  word index into instruction memory = {2'b00, pc[31:2]}
imem_data_i  input  32  instruction word, valid combinationally in the same cycle
if_id_pc_o  output  32  byte PC of the instruction in IF/ID
if_id_pc4_o  output  32  if_id_pc_o + 4
if_id_instr_o  output  32  instruction in IF/ID
if_id_valid_o  output  1  IF/ID holds a real instruction (not a bubble)
misaligned_o  output  1  one-cycle pulse: redirect target had bits[1:0] != 0
halted_o  output  1  fetch unit is in HALT
fetch_count_o  output  32  count of valid instructions latched into IF/ID

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=BOOT; if_id_instr_o=NOP_INSTR; if_id_pc_o=0; if_id_pc4_o=4; if_id_valid_o=0; misaligned_o=0; halted_o=0; fetch_count_o=0. Reset mid-operation discards all state immediately.
- imem_addr_o is purely combinational from pc. The memory is word-indexed and there is zero read latency, so one instruction is fetched per cycle.
- States:
  - BOOT: exactly one cycle after rst_n rises. IF/ID stays a bubble. pc is not advanced. Next state is RUN. A flush in BOOT is honoured (pc=redirect), then the FSM moves to RUN.
  - RUN: normal fetch (priority rules below).
  - HALT: pc is frozen. IF/ID is loaded with a bubble each cycle (valid=0). halted_o=1. Leaves HALT only on flush_i, which redirects and moves the FSM to RUN. stall_i is ignored in HALT.
- RUN priority per cycle: flush_i > stall_i > normal.
  - flush: pc <= {redirect_pc_i[31:2],2'b00}. IF/ID <= bubble (NOP_INSTR, valid=0; pc fields keep their old values). misaligned_o <= |redirect_pc_i[1:0] for one cycle.
  - stall (no flush): pc and all IF/ID outputs hold. fetch_count_o holds.
  - normal: IF/ID <= {imem_data_i, pc, pc+4, valid=1}. pc <= pc+4. fetch_count_o += 1.
  - If the word latched in the normal case equals EBREAK_INSTR: it is latched as valid and counted, pc still advances, and the next state is HALT.
- Simultaneous flush and stall: flush wins. This applies even when the word being fetched is EBREAK, so no HALT occurs.
- Arithmetic: pc+4 and fetch_count_o wrap modulo 2^32 with no flag. A PC wrap from 32'hFFFFFFFC goes to 0.
- misaligned_o is 0 in every cycle without a flush. The unit never generates a misaligned PC.

Test Plan:
1. Reset, then release with memory words 0..3 = 00200513, 00100113, 00250233, 00412223 -> BOOT bubble for one cycle; then if_id_instr_o shows those four words on consecutive cycles with if_id_pc_o = 0,4,8,C; imem_addr_o = 0,1,2,3; fetch_count_o reaches 4.
2. stall_i high for 3 cycles while IF/ID holds pc=8 -> outputs and imem_addr_o unchanged for 3 cycles and fetch_count_o frozen; fetch resumes at pc=C.
3. flush_i with redirect_pc_i=32'h40 while stall_i=1 -> next cycle if_id_valid_o=0 and instr=00000013; the following cycle if_id_pc_o=40 and imem_addr_o moved through 0x10 then 0x11; misaligned_o=0.
4. flush_i with redirect_pc_i=32'h46 -> pc=44 and misaligned_o=1 for exactly one cycle.
5. Memory word at pc=0x10 is 00100073 -> it appears valid in IF/ID, then halted_o=1 and valid=0 thereafter with pc frozen at 0x14; a later flush to 0x0 resumes fetch from word 0.
6. Assert rst_n=0 asynchronously mid-RUN at pc=0x20 -> all outputs return to reset values before the next clock edge; after release a BOOT bubble occurs, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, addresses the word-indexed
// instruction memory, and fills the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misaligned_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_id_pc, if_id_pc_nxt;
  logic [31:0] if_id_instr, if_id_instr_nxt;
  logic        if_id_valid, if_id_valid_nxt;
  logic        misaligned, misaligned_nxt;
  logic [31:0] fetch_count, fetch_count_nxt;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state and next-datapath values: flush beats every state, then stall
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    if_id_valid_nxt = if_id_valid;
    misaligned_nxt  = 1'b0;
    fetch_count_nxt = fetch_count;
    if (flush_i) begin
      pc_nxt          = {redirect_pc_i[31:2], 2'b00};
      if_id_instr_nxt = NOP_INSTR;
      if_id_valid_nxt = 1'b0;
      misaligned_nxt  = |redirect_pc_i[1:0];
      state_nxt       = RUN;
    end else begin
      case (state)
        BOOT: begin
          if_id_instr_nxt = NOP_INSTR;
          if_id_valid_nxt = 1'b0;
          state_nxt       = RUN;
        end
        HALT: begin
          if_id_instr_nxt = NOP_INSTR;
          if_id_valid_nxt = 1'b0;
        end
        RUN: begin
          if (!stall_i) begin
            if_id_instr_nxt = imem_data_i;
            if_id_pc_nxt    = pc;
            if_id_valid_nxt = 1'b1;
            pc_nxt          = pc + 32'd4;
            fetch_count_nxt = fetch_count + 32'd1;
            if (imem_data_i == EBREAK_INSTR) state_nxt = HALT;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // PC and IF/ID pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc          <= pc_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_valid <= if_id_valid_nxt;
      misaligned  <= misaligned_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  assign imem_addr_o   = {2'b00, pc[31:2]};
  assign if_id_pc_o    = if_id_pc;
  assign if_id_pc4_o   = if_id_pc + 32'd4;
  assign if_id_instr_o = if_id_instr;
  assign if_id_valid_o = if_id_valid;
  assign misaligned_o  = misaligned;
  assign halted_o      = (state == HALT);
  assign fetch_count_o = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o, fetch_count_o;
  logic        if_id_valid_o, misaligned_o, halted_o;

  logic [31:0] mem [64];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: architectural view of the fetch unit
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_mis, m_boot, m_halt;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .NOP_INSTR   (NOP),
    .EBREAK_INSTR(EBREAK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_pc4_o  (if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o),
    .misaligned_o (misaligned_o),
    .halted_o     (halted_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  // Zero-latency word-indexed memory (index wraps over 64 words)
  assign imem_data_i = mem[imem_addr_o[5:0]];

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_cnt = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr_o, m_pc >> 2);
    chk("if_id_pc", if_id_pc_o, m_ipc);
    chk("if_id_pc4", if_id_pc4_o, m_ipc + 32'd4);
    chk("if_id_instr", if_id_instr_o, m_instr);
    chk("if_id_valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
    chk("misaligned", {31'd0, misaligned_o}, {31'd0, m_mis});
    chk("halted", {31'd0, halted_o}, {31'd0, m_halt});
    chk("fetch_count", fetch_count_o, m_cnt);
  endtask

  // One clock: drive inputs, advance model, then compare after the edge
  task automatic cycle(input logic st, input logic fl, input logic [31:0] rd);
    logic [31:0] word;
    stall_i = st; flush_i = fl; redirect_pc_i = rd;
    chk("imem_addr_pre", imem_addr_o, m_pc >> 2);
    word  = mem[m_pc[7:2]];
    m_mis = 1'b0;
    if (fl) begin
      m_pc = {rd[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
      m_mis = |rd[1:0]; m_boot = 1'b0; m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (m_halt) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = word; m_ipc = m_pc; m_valid = 1'b1;
      m_cnt = m_cnt + 1; m_pc = m_pc + 4;
      if (word == EBREAK) m_halt = 1'b1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == EBREAK) mem[i] = NOP;
    end
    mem[0] = 32'h0020_0513; mem[1] = 32'h0010_0113;
    mem[2] = 32'h0025_0233; mem[3] = 32'h0041_2223;
    mem[4] = EBREAK;

    // 1: reset, boot bubble, fetch words 0..2
    do_reset();
    cycle(1'b0, 1'b0, '0);               // BOOT
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    // 2: stall three cycles with IF/ID at pc=8, then fetch pc=C
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    // 3: flush+stall while EBREAK at pc=0x10 is on the bus: no halt
    cycle(1'b1, 1'b1, 32'h40);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    // 4: misaligned redirect pulses for one cycle
    cycle(1'b0, 1'b1, 32'h46);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    // 5: EBREAK at 0x10 halts; stall ignored; flush to 0 resumes
    cycle(1'b0, 1'b1, 32'h10);
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(i[0], 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0);
    // PC wrap from FFFFFFFC to 0
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    // 6: asynchronous reset mid-RUN at pc=0x20
    cycle(1'b0, 1'b1, 32'h18);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0);               // BOOT
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic st, fl;
      logic [31:0] rd;
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 19) < 3);
      rd = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3))
                                        : ($urandom & 32'hFF);
      cycle(st, fl, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
